nib_fifo: RTL and testbench
===========================

NIB_FIFO -- requirements
Module: nib_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 4: number of storage entries; power of two, DEPTH >= 2.
REQ-003 The block SHALL have one clock; reset is synchronous and active-low.
REQ-004 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-005 Port rst  input  1: synchronous active-low reset.
REQ-006 Port in_valid  input  1: upstream word available (driven by the register stage's data_out path).
REQ-007 Port in_data  input  WIDTH: upstream word.
REQ-008 Port in_ready  output  1: FIFO can accept a word this cycle.
REQ-009 Port out_valid  output  1: out_data holds a valid word.
REQ-010 Port out_data  output  WIDTH: head-of-queue word.
REQ-011 Port out_ready  input  1: downstream consumes the word this cycle.
REQ-012 Port count  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-013 Port ovf_err  output  1: sticky overflow flag (see Configuration).

Function
REQ-014 Write SHALL occur on a rising edge when in_valid && in_ready; the word is stored at wr_ptr and wr_ptr advances by 1 modulo DEPTH.
REQ-015 Read SHALL occur on a rising edge when out_valid && out_ready; rd_ptr advances by 1 modulo DEPTH.
REQ-016 in_ready SHALL be 1 iff rst is high and count < DEPTH; no write-through when full, even if a read occurs the same cycle.
REQ-017 out_valid SHALL be 1 iff count != 0; out_data SHALL be mem[rd_ptr] combinationally (first-word fall-through) and 0 when out_valid is 0.
REQ-018 Latency: a word written on edge N SHALL appear on out_data/out_valid after edge N when the FIFO was empty before edge N.
REQ-019 count SHALL increment on write-only, decrement on read-only, and hold on simultaneous write and read.
REQ-020 Empty with in_valid and out_ready both high: write only; count 0 -> 1.
REQ-021 Full with out_ready high: read only; count DEPTH -> DEPTH-1; in_ready rises the following cycle.
REQ-022 While out_valid && !out_ready, out_data SHALL stay stable until consumed.
REQ-023 Ordering SHALL be strict FIFO across pointer wrap-around.

Reset
REQ-024 On a rising edge with rst low: wr_ptr, rd_ptr and count SHALL clear to 0, and ovf_err SHALL clear to 0.
REQ-025 During and immediately after reset: out_valid 0, out_data 0; in_ready 0 while rst low and 1 on the first cycle after rst goes high.
REQ-026 Storage contents SHALL not be reset; reset mid-operation SHALL discard all queued words.

Configuration
REQ-027 With macro NIB_FIFO_OVF_EN defined, ovf_err SHALL set on any edge where in_valid is high and in_ready is low, and hold until reset.
REQ-028 Without NIB_FIFO_OVF_EN, ovf_err SHALL be tied to 0 and no overflow logic SHALL be synthesized.

Structure
REQ-029 Package nib_fifo_pkg SHALL hold the default constants NIB_WIDTH=4 and NIB_DEPTH=4, plus a ptr_t typedef sized $clog2(NIB_DEPTH).
REQ-030 Storage SHALL be a sub-module nib_fifo_mem: one write port and one asynchronous read port, no reset. Pointer, count and flag logic SHALL live in nib_fifo.

Verification
REQ-031 Reset: hold rst low 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, count=0, out_data=0.
REQ-032 Fill/drain: write 0xA, 0xC, 0x3, 0x5 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> reads 0xA, 0xC, 0x3, 0x5 in order, count 0, out_valid=0.
REQ-033 Simultaneous: count=2, in_valid=1 and out_ready=1 for 6 cycles with data 0..5 -> count stays 2, output order preserved across wrap.
REQ-034 Full plus read: count=4, in_valid=1 and out_ready=1 on one edge -> only the read occurs, count=3, in_ready=1 next cycle.
REQ-035 Overflow: with NIB_FIFO_OVF_EN, write 0x7 while full -> ovf_err=1, stays 1 after drain, clears on reset; without the macro -> ovf_err=0 throughout.
REQ-036 Mid-op reset: count=3, drive rst low for 1 edge -> count=0, out_valid=0; the next write 0x9 is read back as 0x9.

Source files
------------

// File: rtl/nib_fifo_pkg.sv
// Shared defaults for the nibble FIFO: word width, depth and pointer type.
package nib_fifo_pkg;

   localparam int unsigned NIB_WIDTH = 4;
   localparam int unsigned NIB_DEPTH = 4;
   localparam int unsigned NIB_PTR_W = $clog2(NIB_DEPTH);

   typedef logic [NIB_PTR_W-1:0] ptr_t;

endpackage : nib_fifo_pkg

// File: rtl/nib_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port, no reset.
module nib_fifo_mem
   import nib_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = NIB_WIDTH,
   parameter int unsigned DEPTH = NIB_DEPTH
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [WIDTH-1:0]         rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule : nib_fifo_mem

// File: rtl/nib_fifo.sv
// First-word fall-through FIFO with pointer/occupancy control.
// Optional sticky overflow flag enabled by defining NIB_FIFO_OVF_EN.
module nib_fifo
   import nib_fifo_pkg::*;
#(
   parameter int unsigned WIDTH = NIB_WIDTH,
   parameter int unsigned DEPTH = NIB_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] count,
   output logic                   ovf_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             wr_en, rd_en;
   logic [WIDTH-1:0] rd_data;

   // Handshakes, fall-through output and next-state pointers/occupancy.
   always_comb begin
      in_ready  = rst && (count_q < CW'(DEPTH));
      out_valid = (count_q != '0);
      wr_en     = in_valid && in_ready;
      rd_en     = out_valid && out_ready;
      out_data  = out_valid ? rd_data : '0;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_en && !rd_en) begin
         count_d = count_q + CW'(1);
      end else if (!wr_en && rd_en) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;

`ifdef NIB_FIFO_OVF_EN
   logic ovf_q, ovf_d;

   // Sticky: any offered word that cannot be accepted.
   always_comb begin
      ovf_d = ovf_q || (in_valid && !in_ready);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign ovf_err = ovf_q;
`else
   assign ovf_err = 1'b0;
`endif

   nib_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

endmodule : nib_fifo

// File: tb/tb_nib_fifo.sv
// Directed self-checking bench for nib_fifo (default WIDTH=4, DEPTH=4).
module tb_nib_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] in_data;
   logic       in_ready;
   logic       out_valid;
   logic [3:0] out_data;
   logic       out_ready;
   logic [2:0] count;
   logic       ovf_err;

   int n_cmp = 0;
   int n_err = 0;

`ifdef NIB_FIFO_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   logic [3:0] model_q [$];
   logic [3:0] exp_word;

   always #5 clk = ~clk;

   nib_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .ovf_err   (ovf_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst       = 1'b0;
      in_valid  = 1'b1;
      in_data   = 4'h0;
      out_ready = 1'b0;

      // Reset held two edges with a word offered
      tick();
      tick();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_ovf", 32'(ovf_err), 32'd0);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);
      chk("post_rst_out_valid", 32'(out_valid), 32'd0);

      // Fill
      push(4'hA);
      chk("lat_out_valid", 32'(out_valid), 32'd1);
      chk("lat_out_data", 32'(out_data), 32'hA);
      push(4'hC);
      push(4'h3);
      push(4'h5);
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_data", 32'(out_data), 32'hA);

      // Offer while full: rejected, flags overflow when enabled
      push(4'h7);
      chk("ovf_count", 32'(count), 32'd4);
      chk("ovf_set", 32'(ovf_err), 32'(OVF_EXP));
      chk("ovf_head", 32'(out_data), 32'hA);

      // Drain
      out_ready = 1'b1;
      #1;
      chk("drain0", 32'(out_data), 32'hA);
      tick();
      chk("drain1", 32'(out_data), 32'hC);
      tick();
      chk("drain2", 32'(out_data), 32'h3);
      tick();
      chk("drain3", 32'(out_data), 32'h5);
      tick();
      out_ready = 1'b0;
      #1;
      chk("empty_count", 32'(count), 32'd0);
      chk("empty_out_valid", 32'(out_valid), 32'd0);
      chk("empty_out_data", 32'(out_data), 32'd0);
      chk("ovf_sticky", 32'(ovf_err), 32'(OVF_EXP));

      // Simultaneous read/write at count 2 across pointer wrap
      push(4'hE);
      push(4'hD);
      model_q = '{4'hE, 4'hD};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 4'(i);
         #1;
         exp_word = model_q.pop_front();
         chk("sim_data", 32'(out_data), 32'(exp_word));
         chk("sim_count", 32'(count), 32'd2);
         model_q.push_back(4'(i));
         tick();
      end
      in_valid = 1'b0;
      #1;
      chk("sim_tail0", 32'(out_data), 32'h4);
      tick();
      chk("sim_tail1", 32'(out_data), 32'h5);
      tick();
      out_ready = 1'b0;
      #1;
      chk("sim_empty", 32'(count), 32'd0);

      // Full plus read on the same edge: only the read happens
      push(4'h1);
      push(4'h2);
      push(4'h3);
      push(4'h4);
      chk("fr_full", 32'(count), 32'd4);
      in_valid  = 1'b1;
      in_data   = 4'h8;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("fr_count", 32'(count), 32'd3);
      chk("fr_in_ready", 32'(in_ready), 32'd1);
      chk("fr_head", 32'(out_data), 32'h2);

      // Mid-operation reset discards queued words
      rst = 1'b0;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("mid_count", 32'(count), 32'd0);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_ovf_clr", 32'(ovf_err), 32'd0);
      rst = 1'b1;
      #1;
      chk("mid_in_ready", 32'(in_ready), 32'd1);
      push(4'h9);
      chk("mid_count1", 32'(count), 32'd1);
      chk("mid_data", 32'(out_data), 32'h9);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      #1;
      chk("mid_final_count", 32'(count), 32'd0);
      chk("final_ovf", 32'(ovf_err), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_nib_fifo
